mdiv_ctrl: RTL and testbench
============================

Name: mdiv_ctrl

Overview:
Iterative multiply/divide sequencer that owns the HI/LO architectural registers for the MIPS-style pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the memory stage.
- Runs a radix-2 shift-add multiply or restoring divide over WIDTH iterations and writes HI/LO at completion.
- Drives BUSY, which the hazard logic combines with an MFHI/MFLO in M to stall the front of the pipe.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  single-cycle op request from M stage; already qualified by pipeline valid/not-stalled
OP  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
SRC_A  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
SRC_B  input  WIDTH  rt operand (multiplier / divisor)
BUSY  output  1  operation in flight; HI/LO not yet valid
HI  output  WIDTH  HI register (remainder / product upper half)
LO  output  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset (RESET=1 at clock edge): state IDLE, BUSY=0, HI=0, LO=0, iteration counter=0. RESET takes priority over every other input, including mid-operation; the in-flight op is discarded with no HI/LO write.
- States:
  - IDLE: BUSY=0.
  - RUN: BUSY=1, counter WIDTH-1 down to 0.
  - FIX: BUSY=1, one cycle of sign correction, then HI/LO write.
- Accepted START with OP=none or reserved: no effect in any state; an op in flight continues.
- Accepted START with MULT/MULTU/DIV/DIVU, any state:
  - Latch operands; for signed ops latch magnitudes plus result-sign flags.
  - Go to RUN, counter=WIDTH-1.
  - Any op in flight is aborted and its result never written.
- Accepted START with MTHI/MTLO, any state:
  - HI (resp. LO) <= SRC_A at that edge; other register unchanged.
  - State forced to IDLE, aborting any op in flight. BUSY=0 from the next cycle.
- RUN: one iteration per cycle. Counter=0 goes to FIX.
- FIX: apply sign correction and write HI/LO at the end of the cycle, then return to IDLE.
- Timing: START at edge 0 gives BUSY=1 during cycles 1..WIDTH+1 (33 cycles for WIDTH=32). HI/LO show the new result and BUSY=0 from cycle WIDTH+2.
- HI/LO hold their previous values throughout RUN/FIX.
- Multiply:
  - 2*WIDTH-bit product, unsigned on magnitudes.
  - MULT negates the full 2*WIDTH product in FIX when operand signs differ.
  - HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide:
  - Restoring division on magnitudes.
  - Signed: quotient negated when signs differ; remainder takes the sign of the dividend.
  - DIV of most-negative by -1: LO=most-negative, HI=0 (magnitude wrap, no trap).
- Divide by zero (DIV or DIVU): full latency still taken; LO=all ones, HI=SRC_A as latched (raw, not magnitude).
- Signed magnitude of most-negative value is 2^(WIDTH-1) held in WIDTH bits unsigned; no overflow flag exists.

Test Plan:
- Reset, then MULTU A=FFFFFFFF B=FFFFFFFF -> BUSY high exactly 33 cycles; HI=FFFFFFFE, LO=00000001 from the cycle BUSY drops.
- MULT A=FFFFFFFD(-3) B=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB. Then DIV A=FFFFFFF9(-7) B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU A=00000005 B=00000000 -> after 33 busy cycles LO=FFFFFFFF, HI=00000005. DIV A=80000000 B=FFFFFFFF -> LO=80000000, HI=00000000.
- MTLO A=12345678 while idle, HI preset to 0000ABCD -> LO=12345678 next cycle, HI=0000ABCD, BUSY stays 0.
- Abort cases:
  - DIVU 100/7 started; at busy cycle 10 issue MTHI A=DEADBEEF -> BUSY=0 next cycle, HI=DEADBEEF, LO unchanged.
  - Second MULTU 3*4 issued at busy cycle 20 -> BUSY runs 33 cycles from the new START; HI=0, LO=0000000C.
- RESET asserted at busy cycle 15 of MULTU -> next cycle BUSY=0, HI=0, LO=0. Following START with OP=000 -> no state change.

Source files
------------

// File: rtl/mdiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
//
//   state | meaning
//   IDLE  | no op in flight, HI/LO valid
//   RUN   | one multiply/divide iteration per cycle, counter WIDTH-1 down to 0
//   FIX   | sign correction, HI/LO written at end of cycle
module mdiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] SRC_A,
   input  logic [WIDTH-1:0] SRC_B,
   output logic             BUSY,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t state, nxt;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b, a_raw;
   logic             is_div, neg_res, neg_rem, div_zero;

   logic             start_arith, start_mthi, start_mtlo;
   logic             div_op, sgn_op, a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum, div_trial;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0] fix_hi, fix_lo;

   always_comb begin
      start_arith = START && (OP == OP_MULT || OP == OP_MULTU || OP == OP_DIV || OP == OP_DIVU);
      start_mthi  = START && (OP == OP_MTHI);
      start_mtlo  = START && (OP == OP_MTLO);
      div_op      = (OP == OP_DIV) || (OP == OP_DIVU);
      sgn_op      = (OP == OP_MULT) || (OP == OP_DIV);
      a_neg       = sgn_op && SRC_A[WIDTH-1];
      b_neg       = sgn_op && SRC_B[WIDTH-1];
      mag_a       = a_neg ? -SRC_A : SRC_A;
      mag_b       = b_neg ? -SRC_B : SRC_B;
   end

   // acc_hi/acc_lo hold partial product (multiply) or remainder/quotient (divide)
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
      div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd_b};
      step_hi   = mul_sum[WIDTH:1];
      step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
      if (is_div) begin
         if (!div_trial[WIDTH]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_neg = -prod;
      fix_hi   = neg_res ? prod_neg[2*WIDTH-1:WIDTH] : acc_hi;
      fix_lo   = neg_res ? prod_neg[WIDTH-1:0] : acc_lo;
      if (is_div) begin
         fix_hi = neg_rem ? -acc_hi : acc_hi;
         fix_lo = neg_res ? -acc_lo : acc_lo;
         if (div_zero) begin
            fix_hi = a_raw;
            fix_lo = '1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) state <= S_IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  nxt = S_IDLE;
         S_RUN:   if (cnt == '0) nxt = S_FIX;
         S_FIX:   nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      if (start_arith)                   nxt = S_RUN;
      else if (start_mthi || start_mtlo) nxt = S_IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hi_q     <= '0;
         lo_q     <= '0;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd_b   <= '0;
         a_raw    <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         if (start_arith) begin
            acc_hi   <= '0;
            acc_lo   <= div_op ? mag_a : mag_b;
            opnd_b   <= div_op ? mag_b : mag_a;
            a_raw    <= SRC_A;
            is_div   <= div_op;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= div_op && a_neg;
            div_zero <= div_op && (SRC_B == '0);
            cnt      <= CW'(WIDTH - 1);
         end else if (state == S_RUN) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (cnt != '0) cnt <= cnt - CW'(1);
         end
         // any new HI/LO-affecting request in the FIX cycle discards the pending result
         if (state == S_FIX && !start_arith && !start_mthi && !start_mtlo) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end
         if (start_mthi) hi_q <= SRC_A;
         if (start_mtlo) lo_q <= SRC_A;
      end
   end

   assign BUSY = (state != S_IDLE);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdiv_ctrl.sv
// Scoreboard bench for mdiv_ctrl: stimulus queues expected HI/LO and busy length,
// a monitor compares whenever BUSY falls.
module tb_mdiv_ctrl;
   localparam int W = 32;

   localparam logic [2:0] NONE  = 3'd0;
   localparam logic [2:0] MULT  = 3'd1;
   localparam logic [2:0] MULTU = 3'd2;
   localparam logic [2:0] DIV   = 3'd3;
   localparam logic [2:0] DIVU  = 3'd4;
   localparam logic [2:0] MTHI  = 3'd5;
   localparam logic [2:0] MTLO  = 3'd6;
   localparam logic [2:0] RSVD  = 3'd7;

   logic         CLK = 1'b0;
   logic         RESET, START;
   logic [2:0]   OP;
   logic [W-1:0] SRC_A, SRC_B;
   logic         BUSY;
   logic [W-1:0] HI, LO;

   always #5 CLK = ~CLK;

   mdiv_ctrl #(.WIDTH(W)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
      .SRC_A(SRC_A), .SRC_B(SRC_B), .BUSY(BUSY), .HI(HI), .LO(LO)
   );

   typedef struct {
      string        name;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           len;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic prev_busy = 1'b0;
   int   busy_len  = 0;

   always @(negedge CLK) begin
      exp_t e;
      if (BUSY === 1'b1) begin
         busy_len++;
      end else if (prev_busy) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got HI=%h LO=%h expected no completion", HI, LO);
         end else begin
            e = sb.pop_front();
            check({e.name, "_hi"}, HI, e.hi);
            check({e.name, "_lo"}, LO, e.lo);
            if (e.len != 0) check({e.name, "_busy_len"}, W'(busy_len), W'(e.len));
         end
         busy_len = 0;
      end
      if (START === 1'b1 && OP inside {MULT, MULTU, DIV, DIVU}) busy_len = 0;
      prev_busy = (BUSY === 1'b1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      START = 1'b1;
      OP    = op;
      SRC_A = a;
      SRC_B = b;
      tick();
      START = 1'b0;
      OP    = NONE;
   endtask

   task automatic push(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo, input int len);
      exp_t e;
      e.name = name;
      e.hi   = hi;
      e.lo   = lo;
      e.len  = len;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (BUSY !== 1'b0 && k < 100) begin
         tick();
         k++;
      end
      if (k >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got BUSY=%b after %0d cycles expected 0", name, BUSY, k);
      end
      tick();
   endtask

   task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo);
      push(name, hi, lo, W + 1);
      issue(op, a, b);
      wait_idle(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; START = 1'b0; OP = NONE; SRC_A = '0; SRC_B = '0;
      tick(); tick(); tick();
      RESET = 1'b0;
      check("rst_busy", W'(BUSY), 0);
      check("rst_hi", HI, 32'h0);
      check("rst_lo", LO, 32'h0);

      run("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

      // MULT with hold check mid-run and an ignored OP=none request
      push("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB, W + 1);
      issue(MULT, 32'hFFFFFFFD, 32'h00000007);
      repeat (4) tick();
      check("hold_busy", W'(BUSY), 1);
      check("hold_hi", HI, 32'hFFFFFFFE);
      check("hold_lo", LO, 32'h00000001);
      issue(NONE, 32'h11111111, 32'h22222222);
      wait_idle("mult_neg");

      run("div_neg",    DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run("divu_zero",  DIVU, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
      run("div_ovf",    DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run("div_zero_s", DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
      run("divu_100_7", DIVU, 32'd100,      32'd7,        32'd2,        32'd14);
      run("mult_nn",    MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E);
      run("mult_minv",  MULT, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000);
      run("div_pos_neg", DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

      issue(MTHI, 32'h0000ABCD, 32'h0);
      check("mthi_hi", HI, 32'h0000ABCD);
      check("mthi_lo", LO, 32'hFFFFFFFD);
      issue(MTLO, 32'h12345678, 32'h0);
      check("mtlo_lo", LO, 32'h12345678);
      check("mtlo_hi", HI, 32'h0000ABCD);
      check("mtlo_busy", W'(BUSY), 0);

      // MTHI aborts a divide at busy cycle 10
      issue(DIVU, 32'd100, 32'd7);
      repeat (9) tick();
      push("mthi_abort", 32'hDEADBEEF, 32'h12345678, 10);
      issue(MTHI, 32'hDEADBEEF, 32'h0);
      check("abort_busy", W'(BUSY), 0);
      check("abort_hi", HI, 32'hDEADBEEF);
      check("abort_lo", LO, 32'h12345678);
      tick();

      // second MULTU restarts at busy cycle 20
      issue(MULTU, 32'd5, 32'd5);
      repeat (19) tick();
      push("restart", 32'h0, 32'h0000000C, W + 1);
      issue(MULTU, 32'd3, 32'd4);
      wait_idle("restart");

      // RESET at busy cycle 15
      issue(MULTU, 32'd7, 32'd9);
      repeat (14) tick();
      push("mid_reset", 32'h0, 32'h0, 15);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("mrst_busy", W'(BUSY), 0);
      check("mrst_hi", HI, 32'h0);
      check("mrst_lo", LO, 32'h0);
      issue(NONE, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      check("none_busy", W'(BUSY), 0);
      check("none_hi", HI, 32'h0);
      check("none_lo", LO, 32'h0);
      issue(RSVD, 32'hFFFFFFFF, 32'h00000003);
      tick();
      check("rsvd_busy", W'(BUSY), 0);
      check("rsvd_hi", HI, 32'h0);
      check("rsvd_lo", LO, 32'h0);

      tick();
      check("sb_empty", W'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
